// File: rtl/divider_8_bit_sequential_pkg.sv
// divider_8_bit_sequential_pkg: shared arithmetic constants and FSM encoding for the divider
package divider_8_bit_sequential_pkg;
   localparam int DIV_WIDTH = 8;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/divider_8_bit_sequential_trial_subtract.sv
// trial_subtract: WIDTH+1-bit S - {0,D} via invert-and-carry-in; no_borrow is the raw carry-out
module trial_subtract
   import divider_8_bit_sequential_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   s,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   diff,
   output logic             no_borrow
);
   logic [WIDTH:0] d_inv;
   assign d_inv = {1'b0, d} ^ {(WIDTH+1){1'b1}};
   assign {no_borrow, diff} = {1'b0, s} + {1'b0, d_inv} + (WIDTH+2)'(1);
endmodule

// File: rtl/divider_8_bit_sequential.sv
// divider_8_bit_sequential: iterative unsigned restoring divider with start/busy/done handshake
module divider_8_bit_sequential
   import divider_8_bit_sequential_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [DIV_WIDTH-1:0] quotient,
   output logic [DIV_WIDTH-1:0] remainder,
   output logic                 div_by_zero
);
   localparam int WIDTH = DIV_WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;
   logic [1:0]       state;
   logic [WIDTH-1:0] q, d;
   logic [WIDTH:0]   r, s, diff;
   logic             no_borrow;
   logic [CW-1:0]    cnt;
   // R never exceeds D after an iteration, so its top bit falls off the shift
   assign s = (WIDTH+1)'({r, q[WIDTH-1]});
   trial_subtract #(.WIDTH(WIDTH)) u_sub (.s(s), .d(d), .diff(diff), .no_borrow(no_borrow));
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign quotient = q;
   assign remainder = r[WIDTH-1:0];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         q <= '0;
         r <= '0;
         d <= '0;
         cnt <= '0;
         div_by_zero <= 1'b0;
      end else if (state == IDLE) begin
         if (start && divisor != '0) begin
            state <= BUSY;
            q <= dividend;
            d <= divisor;
            r <= '0;
            cnt <= '0;
            div_by_zero <= 1'b0;
         end else if (start) begin
            state <= DONE;
            q <= DIV_ZERO_Q;
            r <= {1'b0, dividend};
            d <= divisor;
            cnt <= '0;
            div_by_zero <= 1'b1;
         end
      end else if (state == BUSY) begin
         r <= no_borrow ? diff : s;
         q <= {q[WIDTH-2:0], no_borrow};
         cnt <= cnt + CW'(1);
         if (cnt == CW'(WIDTH-1)) state <= DONE;
      end else begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_divider_8_bit_sequential.sv
// tb_divider_8_bit_sequential: directed vectors, expected results queued and checked on each done pulse
module tb_divider_8_bit_sequential;
   typedef struct {
      logic [7:0] a, b, q, r;
      logic z;
   } exp_t;
   logic clk = 1'b0, rst_n, start;
   logic [7:0] dividend, divisor, quotient, remainder;
   logic busy, done, div_by_zero;
   exp_t exp_q[$];
   int n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   divider_8_bit_sequential dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );
   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_quotient"}, int'(quotient), 0);
      chk({tag, "_remainder"}, int'(remainder), 0);
      chk({tag, "_dbz"}, int'(div_by_zero), 0);
   endtask
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit push);
      exp_t e;
      start = 1'b1;
      dividend = a;
      divisor = b;
      if (push) begin
         e.a = a;
         e.b = b;
         e.q = (b == 0) ? 8'hFF : a / b;
         e.r = (b == 0) ? a : a % b;
         e.z = (b == 0);
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      dividend = 8'($urandom);
      divisor = 8'($urandom);
   endtask
   task automatic wait_done(input int exp_lat);
      int lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 0, 1);
      else if (exp_lat != 0) chk("latency", lat, exp_lat);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
   endtask
   task automatic run(input logic [7:0] a, input logic [7:0] b);
      launch(a, b, 1'b1);
      wait_done((b == 0) ? 1 : 9);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.z));
            if (e.b != 0) begin
               chk("identity", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
               chk("rem_lt_div", int'(remainder < e.b), 1);
            end
         end
      end
   end
   initial begin
      logic [7:0] va[9] = '{8'd0, 8'd1, 8'd7, 8'd100, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
      logic [7:0] vb[10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd16, 8'd128, 8'd254, 8'd255};
      rst_n = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(8'd200, 8'd7, 1'b1);
      chk("busy_after_start", int'(busy), 1);
      wait_done(9);
      run(8'd255, 8'd1);
      run(8'd5, 8'd9);
      repeat (3) @(negedge clk);
      chk("hold_quotient", int'(quotient), 0);
      chk("hold_remainder", int'(remainder), 5);
      chk("hold_done", int'(done), 0);
      run(8'd100, 8'd0);
      launch(8'd10, 8'd3, 1'b1);
      chk("dbz_cleared", int'(div_by_zero), 0);
      wait_done(9);
      launch(8'd200, 8'd7, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1;
      dividend = 8'd10;
      divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(0);
      repeat (12) @(negedge clk);
      launch(8'd255, 8'd16, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("no_done_after_abort", int'(done), 0);
      run(8'd255, 8'd16);
      foreach (va[i]) foreach (vb[j]) run(va[i], vb[j]);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
